// File: rtl/tdc_fifo_uart_tx_pkg.sv
// tdc_fifo_uart_tx_pkg: FSM state codes and UART line constants shared by the FIFO-to-UART drain.
package tdc_fifo_uart_tx_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] LATCH = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] PAR   = 3'd5;
  localparam logic [2:0] STOP  = 3'd6;
  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/tdc_fifo_uart_tx_baud_tick.sv
// tdc_baud_tick: per-bit down-counter; reloads on load and flags the final cycle of each bit.
module tdc_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic SYSCLK,
  input  logic RESET,
  input  logic load,
  input  logic en,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge SYSCLK or posedge RESET)
    if (RESET) cnt <= '0;
    else if (load) cnt <= 16'(CLKS_PER_BIT - 1);
    else if (en && cnt != '0) cnt <= cnt - 16'd1;
endmodule

// File: rtl/tdc_fifo_uart_tx.sv
// tdc_fifo_uart_tx: drains the TDC byte FIFO one frame at a time onto a UART line (8N1).
// Define TDC_UART_PARITY_EN for 8E1 framing with an even parity bit after the data bits.
module tdc_fifo_uart_tx
  import tdc_fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic             SYSCLK,
  input  logic             RESET,
  input  logic             fifo_data_available,
  input  logic [7:0]       fifo_dout,
  output logic             read_fifo,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic [CNT_W-1:0] tx_count
);
  logic [2:0] state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       tick;
  logic       load;
  logic       en;
`ifdef TDC_UART_PARITY_EN
  logic       par;
  assign en = state == START || state == DATA || state == PAR || state == STOP;
`else
  assign en = state == START || state == DATA || state == STOP;
`endif
  assign load = state == LATCH || tick;
  tdc_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .SYSCLK(SYSCLK),
    .RESET (RESET),
    .load  (load),
    .en    (en),
    .tick  (tick)
  );
  always_ff @(posedge SYSCLK or posedge RESET)
    if (RESET) begin
      state     <= IDLE;
      read_fifo <= 1'b0;
      uart_tx   <= UART_IDLE;
      tx_busy   <= 1'b0;
      tx_count  <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
`ifdef TDC_UART_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          read_fifo <= fifo_data_available;
          tx_busy   <= fifo_data_available;
          state     <= fifo_data_available ? RD : IDLE;
        end
        RD: begin
          read_fifo <= 1'b0;
          state     <= LATCH;
        end
        LATCH: begin
          shreg   <= fifo_dout;
          uart_tx <= UART_START;
          bit_idx <= '0;
          state   <= START;
`ifdef TDC_UART_PARITY_EN
          par     <= ^fifo_dout;
`endif
        end
        START: if (tick) begin
          uart_tx <= shreg[0];
          shreg   <= shreg >> 1;
          state   <= DATA;
        end
        DATA: if (tick) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef TDC_UART_PARITY_EN
            uart_tx <= par;
            state   <= PAR;
`else
            uart_tx <= UART_IDLE;
            state   <= STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef TDC_UART_PARITY_EN
        PAR: if (tick) begin
          uart_tx <= UART_IDLE;
          state   <= STOP;
        end
`endif
        STOP: if (tick) begin
          tx_count <= tx_count + CNT_W'(1);
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tdc_fifo_uart_tx.sv
// tb_tdc_fifo_uart_tx: directed plus random frames checked against a bit-list UART frame model and a 1-cycle-latency FIFO.
module tb_tdc_fifo_uart_tx;
  localparam int CPB = 8;
`ifdef TDC_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic        SYSCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        fifo_data_available;
  logic [7:0]  fifo_dout = 8'h00;
  logic        read_fifo;
  logic        uart_tx;
  logic        tx_busy;
  logic [15:0] tx_count;
  logic [7:0]  mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        read_prev = 1'b0;
  logic        bad_read = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_count = 16'd0;
  logic [7:0]  model_reads = 8'd0;

  tdc_fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .SYSCLK             (SYSCLK),
    .RESET              (RESET),
    .fifo_data_available(fifo_data_available),
    .fifo_dout          (fifo_dout),
    .read_fifo          (read_fifo),
    .uart_tx            (uart_tx),
    .tx_busy            (tx_busy),
    .tx_count           (tx_count)
  );

  always #5 SYSCLK = ~SYSCLK;
  assign fifo_data_available = wr_ptr != rd_ptr;

  always @(posedge SYSCLK) begin
    if (read_fifo && (wr_ptr == rd_ptr || read_prev)) bad_read <= 1'b1;
    if (read_fifo && wr_ptr != rd_ptr) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
    read_prev <= read_fifo;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_read(output int n);
    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
    end while (read_fifo !== 1'b1 && n < 300);
    check("read_strobe", read_fifo, 1);
    model_reads = model_reads + 8'd1;
  endtask

  task automatic frame(input logic [7:0] d, input bit b2b);
    int n;
    logic bits [NB];
    logic [CPB-1:0] s;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (NB == 11) bits[9] = ^d;
    bits[NB-1] = 1'b1;
    wait_read(n);
    if (b2b) check("b2b_gap", n, 1);
    check("busy_at_read", tx_busy, 1);
    @(negedge SYSCLK);
    check("strobe_width", read_fifo, 0);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge SYSCLK);
        s[c] = uart_tx;
      end
      check($sformatf("line_%02h_bit%0d", d, b), 32'(s), bits[b] ? 32'(8'hFF) : 32'd0);
    end
    check("busy_last_stop", tx_busy, 1);
    @(negedge SYSCLK);
    model_count = model_count + 16'd1;
    check("busy_end", tx_busy, 0);
    check("tx_count", tx_count, 32'(model_count));
    check("line_idle", uart_tx, 1);
    check("reads", rd_ptr, 32'(model_reads));
    check("no_bad_read", bad_read, 0);
  endtask

  initial begin
    logic idle_bad;
    logic [7:0] d;
    int n;
    repeat (3) @(negedge SYSCLK);
    check("rst_tx", uart_tx, 1);
    check("rst_read", read_fifo, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_count", tx_count, 0);
    RESET = 1'b0;
    idle_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge SYSCLK);
      if (uart_tx !== 1'b1 || read_fifo !== 1'b0 || tx_count !== 16'd0 || tx_busy !== 1'b0) idle_bad = 1'b1;
    end
    check("idle_1000", idle_bad, 0);

    push(8'hA5);
    frame(8'hA5, 0);

    push(8'h00); push(8'hFF); push(8'h3C);
    frame(8'h00, 0);
    frame(8'hFF, 1);
    frame(8'h3C, 1);

    push(8'h07); push(8'h03);
    frame(8'h07, 0);
    frame(8'h03, 1);

    d = 8'($urandom) & 8'hEF;
    push(d);
    wait_read(n);
    repeat (2 + 5 * CPB + 3) @(negedge SYSCLK);
    check("pre_reset_bit4", uart_tx, 0);
    RESET = 1'b1;
    #1;
    check("reset_tx_async", uart_tx, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_count", tx_count, 0);
    model_count = 16'd0;
    repeat (2) @(negedge SYSCLK);
    RESET = 1'b0;
    repeat (3) @(negedge SYSCLK);
    check("post_reset_idle", uart_tx, 1);
    d = 8'($urandom);
    push(d);
    frame(d, 0);

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      push(d);
      if (i % 2 == 0) begin
        logic [7:0] d2;
        d2 = 8'($urandom);
        push(d2);
        frame(d, 0);
        frame(d2, 1);
      end else begin
        frame(d, 0);
      end
      repeat ($urandom_range(0, 20)) @(negedge SYSCLK);
    end

    force dut.tx_count = 16'hFFFF;
    #1;
    release dut.tx_count;
    #1;
    model_count = 16'hFFFF;
    check("forced_count", tx_count, 32'h0000FFFF);
    d = 8'($urandom);
    push(d);
    frame(d, 0);
    check("wrap_count", tx_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
